// File: rtl/mb32_arb.sv
// mb32_arb: two-master arbiter (m0 data/stack, m1 fetch) for the mb32 1-cycle-latency memory bus.
// Optional: define MB32_ARB_RR_EN for round-robin tie-breaking instead of fixed m0 priority.
module mb32_arb #(
    parameter int unsigned ASZ      = 15,
    parameter int unsigned DSZ      = 32,
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           m0_req,
    input  logic           m0_lock,
    input  logic           m0_we,
    input  logic [3:0]     m0_bmsk,
    input  logic [ASZ-1:0] m0_ai,
    input  logic [DSZ-1:0] m0_vi,
    output logic           m0_gnt,
    output logic           m0_rv,
    output logic [DSZ-1:0] m0_vo,
    input  logic           m1_req,
    input  logic           m1_we,
    input  logic [3:0]     m1_bmsk,
    input  logic [ASZ-1:0] m1_ai,
    input  logic [DSZ-1:0] m1_vi,
    output logic           m1_gnt,
    output logic           m1_rv,
    output logic [DSZ-1:0] m1_vo,
    output logic           mem_we,
    output logic [3:0]     mem_bmsk,
    output logic [ASZ-1:0] mem_ai,
    output logic [DSZ-1:0] mem_vi,
    input  logic [DSZ-1:0] mem_vo
);

    localparam int unsigned WCW = ($clog2(WAIT_MAX + 1) > 3) ? $clog2(WAIT_MAX + 1) : 3;
    localparam logic [WCW-1:0] WAIT_LIM = WCW'(WAIT_MAX);

    typedef enum logic {
        IDLE,
        LOCK0
    } state_e;

    state_e         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           last_q, last_d;
    logic           m0_rv_q, m0_rv_d;
    logic           m1_rv_q, m1_rv_d;
    logic           tie_m1;

    // Tie-break when both request: starvation override always wins.
`ifdef MB32_ARB_RR_EN
    assign tie_m1 = (wait_cnt_q == WAIT_LIM) || !last_q;
`else
    assign tie_m1 = (wait_cnt_q == WAIT_LIM);
`endif

    always_comb begin
        state_d = state_q;
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;

        if (state_q == LOCK0 && m0_lock) begin
            m0_gnt = m0_req;
        end else begin
            // Lock release falls through to normal arbitration in the same cycle.
            state_d = IDLE;
            if (m0_req && m1_req) begin
                m1_gnt = tie_m1;
                m0_gnt = !tie_m1;
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
            if (m0_gnt && m0_lock) begin
                state_d = LOCK0;
            end
        end

        if (rst) begin
            m0_gnt = 1'b0;
            m1_gnt = 1'b0;
        end

        if (m1_req && !m1_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end

        last_d = last_q;
        if (m0_gnt) last_d = 1'b0;
        if (m1_gnt) last_d = 1'b1;

        m0_rv_d = m0_gnt && !m0_we;
        m1_rv_d = m1_gnt && !m1_we;

        if (m1_gnt) begin
            mem_we   = m1_we;
            mem_bmsk = m1_bmsk;
            mem_ai   = m1_ai;
            mem_vi   = m1_vi;
        end else begin
            mem_we   = m0_gnt && m0_we;
            mem_bmsk = m0_bmsk;
            mem_ai   = m0_ai;
            mem_vi   = m0_vi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            last_q     <= 1'b1;
            m0_rv_q    <= 1'b0;
            m1_rv_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            last_q     <= last_d;
            m0_rv_q    <= m0_rv_d;
            m1_rv_q    <= m1_rv_d;
        end
    end

    assign m0_rv = m0_rv_q;
    assign m1_rv = m1_rv_q;
    assign m0_vo = mem_vo;
    assign m1_vo = mem_vo;

endmodule

// File: tb/tb_mb32_arb.sv
// tb_mb32_arb: scoreboard bench for mb32_arb with a behavioural arbiter/memory reference model.
module tb_mb32_arb;

    localparam int ASZ      = 15;
    localparam int DSZ      = 32;
    localparam int WAIT_MAX = 8;
`ifdef MB32_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           m0_req, m0_lock, m0_we;
    logic [3:0]     m0_bmsk;
    logic [ASZ-1:0] m0_ai;
    logic [DSZ-1:0] m0_vi;
    logic           m0_gnt, m0_rv;
    logic [DSZ-1:0] m0_vo;
    logic           m1_req, m1_we;
    logic [3:0]     m1_bmsk;
    logic [ASZ-1:0] m1_ai;
    logic [DSZ-1:0] m1_vi;
    logic           m1_gnt, m1_rv;
    logic [DSZ-1:0] m1_vo;
    logic           mem_we;
    logic [3:0]     mem_bmsk;
    logic [ASZ-1:0] mem_ai;
    logic [DSZ-1:0] mem_vi;
    logic [DSZ-1:0] mem_vo;

    always #5 clk = ~clk;

    mb32_arb #(.ASZ(ASZ), .DSZ(DSZ), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_bmsk(m0_bmsk),
        .m0_ai(m0_ai), .m0_vi(m0_vi), .m0_gnt(m0_gnt), .m0_rv(m0_rv), .m0_vo(m0_vo),
        .m1_req(m1_req), .m1_we(m1_we), .m1_bmsk(m1_bmsk),
        .m1_ai(m1_ai), .m1_vi(m1_vi), .m1_gnt(m1_gnt), .m1_rv(m1_rv), .m1_vo(m1_vo),
        .mem_we(mem_we), .mem_bmsk(mem_bmsk), .mem_ai(mem_ai), .mem_vi(mem_vi),
        .mem_vo(mem_vo)
    );

    // Bus slave: 64-word window, byte-masked writes, 1-cycle read latency.
    logic [31:0] slave_mem [64];
    logic [31:0] ref_mem   [64];
    logic        load;
    always @(posedge clk) begin
        if (load) begin
            slave_mem <= ref_mem;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_bmsk[b]) slave_mem[mem_ai[5:0]][8*b +: 8] <= mem_vi[8*b +: 8];
        end
        mem_vo <= slave_mem[mem_ai[5:0]];
    end

    typedef struct {
        bit        rst;
        bit        r0, l0, w0;
        bit [3:0]  b0;
        bit [14:0] a0;
        bit [31:0] v0;
        bit        r1, w1;
        bit [3:0]  b1;
        bit [14:0] a1;
        bit [31:0] v1;
    } stim_t;

    typedef struct {
        int        cyc;
        bit        g0, g1, we;
        bit [3:0]  bmsk;
        bit [14:0] ai;
        bit [31:0] vi;
    } gexp_t;

    typedef struct {
        bit        chk;
        bit        rv0, rv1;
        bit [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference arbiter state.
    bit locked = 1'b0;
    int wait_n = 0;
    int last_m = 1;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", name, c, act, exp);
    endtask

    task automatic drive_cycle(input stim_t s);
        gexp_t     g;
        rexp_t     r;
        bit        e0, e1;
        bit        both;
        bit [31:0] w;
        @(posedge clk);
        #1;
        load    = 1'b0;
        cyc++;
        rst     = s.rst;
        m0_req  = s.r0; m0_lock = s.l0; m0_we = s.w0; m0_bmsk = s.b0; m0_ai = s.a0; m0_vi = s.v0;
        m1_req  = s.r1; m1_we   = s.w1; m1_bmsk = s.b1; m1_ai = s.a1; m1_vi = s.v1;

        e0 = 1'b0;
        e1 = 1'b0;
        both = s.r0 && s.r1;
        if (!s.rst) begin
            if (locked && s.l0)          e0 = s.r0;
            else if (!both)              begin e0 = s.r0; e1 = s.r1; end
            else if (wait_n >= WAIT_MAX) e1 = 1'b1;
            else if (RR && last_m == 0)  e1 = 1'b1;
            else                         e0 = 1'b1;
        end

        g.cyc  = cyc;
        g.g0   = e0;
        g.g1   = e1;
        g.we   = (e0 && s.w0) || (e1 && s.w1);
        g.bmsk = e1 ? s.b1 : s.b0;
        g.ai   = e1 ? s.a1 : s.a0;
        g.vi   = e1 ? s.v1 : s.v0;
        gq.push_back(g);

        r.chk  = 1'b1;
        r.rv0  = e0 && !s.w0;
        r.rv1  = e1 && !s.w1;
        r.data = ref_mem[g.ai[5:0]];
        rq.push_back(r);

        if (g.we) begin
            w = ref_mem[g.ai[5:0]];
            for (int b = 0; b < 4; b++)
                if (g.bmsk[b]) w[8*b +: 8] = g.vi[8*b +: 8];
            ref_mem[g.ai[5:0]] = w;
        end

        if (s.rst) begin
            locked = 1'b0;
            wait_n = 0;
            last_m = 1;
        end else begin
            locked = (locked && s.l0) || (e0 && s.l0);
            if (s.r1 && !e1) wait_n = (wait_n < WAIT_MAX) ? wait_n + 1 : WAIT_MAX;
            else             wait_n = 0;
            if (e0) last_m = 0;
            if (e1) last_m = 1;
        end
    endtask

    // Monitor: consumes one grant expectation and one response expectation per cycle.
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            if (gq.size() != 0 && rq.size() != 0) begin
                g = gq.pop_front();
                r = rq.pop_front();
                chk("m0_gnt", g.cyc, 32'(m0_gnt), 32'(g.g0));
                chk("m1_gnt", g.cyc, 32'(m1_gnt), 32'(g.g1));
                chk("mem_we", g.cyc, 32'(mem_we), 32'(g.we));
                if (g.g0 || g.g1) chk("mem_ai", g.cyc, 32'(mem_ai), 32'(g.ai));
                if (g.we) begin
                    chk("mem_bmsk", g.cyc, 32'(mem_bmsk), 32'(g.bmsk));
                    chk("mem_vi", g.cyc, mem_vi, g.vi);
                end
                if (r.chk) begin
                    chk("m0_rv", g.cyc, 32'(m0_rv), 32'(r.rv0));
                    chk("m1_rv", g.cyc, 32'(m1_rv), 32'(r.rv1));
                    if (r.rv0) chk("m0_vo", g.cyc, m0_vo, r.data);
                    if (r.rv1) chk("m1_vo", g.cyc, m1_vo, r.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        rexp_t r0;
        bit    prev_l;

        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[16] = 32'hDEADBEEF;
        load = 1'b1;
        rst = 1'b1;
        m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b0; m0_bmsk = '0; m0_ai = '0; m0_vi = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_bmsk = '0; m1_ai = '0; m1_vi = '0;
        r0 = '{chk: 1'b0, rv0: 1'b0, rv1: 1'b0, data: 32'h0};
        rq.push_back(r0);

        // Reset with both requesting, then m0 must win the first free cycle.
        s = '{default: 0};
        s.rst = 1'b1; s.r0 = 1'b1; s.r1 = 1'b1;
        repeat (2) drive_cycle(s);
        s.rst = 1'b0;
        drive_cycle(s);

        // m0 read of the preloaded word, then an idle cycle for the response.
        s = '{default: 0};
        s.r0 = 1'b1; s.b0 = 4'hF; s.a0 = 15'h10;
        drive_cycle(s);
        s = '{default: 0};
        drive_cycle(s);

        // Both held continuously: exercises starvation override / alternation.
        s = '{default: 0};
        s.r0 = 1'b1; s.r1 = 1'b1; s.a0 = 15'h3; s.a1 = 15'h4;
        repeat (20) drive_cycle(s);
        s = '{default: 0};
        drive_cycle(s);

        // Locked RMW from m0 while m1 waits, then release.
        s = '{default: 0};
        s.r0 = 1'b1; s.l0 = 1'b1; s.a0 = 15'h10; s.r1 = 1'b1; s.a1 = 15'h5;
        drive_cycle(s);
        for (int i = 0; i < 20; i++) begin
            s.r0 = 1'($urandom_range(0, 1));
            s.w0 = 1'($urandom_range(0, 1));
            s.b0 = 4'($urandom);
            s.v0 = $urandom;
            drive_cycle(s);
        end
        s.l0 = 1'b0; s.r0 = 1'b1; s.w0 = 1'b0;
        drive_cycle(s);

        // m1 partial write followed by readback from m0.
        s = '{default: 0};
        s.r1 = 1'b1; s.w1 = 1'b1; s.b1 = 4'b0011; s.a1 = 15'h20; s.v1 = 32'h12345678;
        drive_cycle(s);
        s = '{default: 0};
        s.r0 = 1'b1; s.a0 = 15'h20;
        drive_cycle(s);

        // Randomised traffic with occasional locks and resets.
        prev_l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s.rst = ($urandom_range(0, 299) == 0);
            s.r0  = ($urandom_range(0, 2) != 0);
            s.l0  = prev_l ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            s.w0  = 1'($urandom_range(0, 1));
            s.b0  = 4'($urandom);
            s.a0  = 15'($urandom);
            s.v0  = $urandom;
            s.r1  = ($urandom_range(0, 2) != 0);
            s.w1  = 1'($urandom_range(0, 1));
            s.b1  = 4'($urandom);
            s.a1  = 15'($urandom);
            s.v1  = $urandom;
            prev_l = s.l0;
            drive_cycle(s);
        end

        s = '{default: 0};
        drive_cycle(s);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
